// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: req/ack instruction fetch, FETCH/DECODE/EXEC/WB sequencing,
// beq, halt, per-instruction retire trace and a combinational debug register read.
module multicycle_cpu #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    imem_req_o,
  output logic [XLEN-1:0]         imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [31:0]             imem_data_i,
  output logic                    retire_o,
  output logic [XLEN-1:0]         retire_pc_o,
  output logic                    halted_o,
  input  logic [$clog2(NREG)-1:0] dbg_raddr_i,
  output logic [XLEN-1:0]         dbg_rdata_o
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t          r_state, w_state_next;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_result, r_next_pc;
  logic [31:0]     r_ir;
  logic            r_wen, r_halt;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_regs [NREG];

  logic [5:0]      w_opcode, w_funct;
  logic [AW-1:0]   w_rs, w_rt, w_rd;
  logic [XLEN-1:0] w_imm, w_pc_plus4;
  logic            w_unused;

  // Register index fields keep only the low AW bits when NREG < 32.
  assign w_opcode   = r_ir[31:26];
  assign w_funct    = r_ir[5:0];
  assign w_rs       = r_ir[21 +: AW];
  assign w_rt       = r_ir[16 +: AW];
  assign w_rd       = r_ir[11 +: AW];
  assign w_imm      = XLEN'($signed(r_ir[15:0]));
  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_unused   = ^r_ir;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_state_next = S_FETCH;
      S_FETCH:  if (imem_ack_i) w_state_next = S_DECODE;
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC:   w_state_next = S_WB;
      S_WB:     w_state_next = r_halt ? S_HALT : S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_next_pc <= '0;
      r_wen     <= 1'b0;
      r_halt    <= 1'b0;
      r_waddr   <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_FETCH: if (imem_ack_i) r_ir <= imem_data_i;
        S_DECODE: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
        end
        S_EXEC: begin
          r_wen     <= 1'b0;
          r_halt    <= 1'b0;
          r_waddr   <= w_rd;
          r_result  <= '0;
          r_next_pc <= w_pc_plus4;
          case (w_opcode)
            6'b000000: begin
              r_wen <= 1'b1;
              case (w_funct)
                6'b100000: r_result <= r_a + r_b;
                6'b100010: r_result <= r_a - r_b;
                6'b100100: r_result <= r_a & r_b;
                6'b100101: r_result <= r_a | r_b;
                6'b011000: r_result <= r_a * r_b;
                default:   r_wen <= 1'b0;
              endcase
            end
            6'b001000: begin
              r_wen    <= 1'b1;
              r_waddr  <= w_rt;
              r_result <= r_a + w_imm;
            end
            6'b000100: if (r_a == r_b) r_next_pc <= w_pc_plus4 + (w_imm << 2);
            6'b111111: r_halt <= 1'b1;
            default: ;
          endcase
        end
        S_WB: begin
          r_pc <= r_next_pc;
          // Register 0 is never written, so it reads as zero everywhere.
          if (r_wen && (r_waddr != '0)) r_regs[r_waddr] <= r_result;
        end
        default: ;
      endcase
    end
  end

  assign imem_req_o  = (r_state == S_FETCH);
  assign imem_addr_o = r_pc;
  assign retire_o    = (r_state == S_WB);
  assign retire_pc_o = retire_o ? r_pc : '0;
  assign halted_o    = (r_state == S_HALT);
  assign dbg_rdata_o = r_regs[dbg_raddr_i];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed timing checks plus random programs run on a
// 32-bit/32-register and a 16-bit/8-register instance against an ISA-level model.
module tb_multicycle_cpu;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic        man_ack = 1'b0, rnd_ack = 1'b0, auto_ack = 1'b0, ack;
  int          wait_max = 0;
  int          n_checks = 0, n_errors = 0;
  logic [31:0] mem [64];

  logic        req0, ret0, halt0, req1, ret1, halt1;
  logic [31:0] addr0, rpc0, dbg0, data0, data1;
  logic [15:0] addr1, rpc1, dbg1;
  logic [4:0]  ra0 = '0;
  logic [2:0]  ra1 = '0;

  logic [63:0] q0[$], q1[$];
  logic [63:0] m_pcs [2][64];
  logic [63:0] m_reg [2][32];
  int          m_n [2];

  localparam logic [31:0] HALT = 32'hFC00_0000;

  assign ack   = auto_ack ? rnd_ack : man_ack;
  assign data0 = mem[addr0[7:2]];
  assign data1 = mem[addr1[7:2]];

  multicycle_cpu dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .imem_req_o(req0), .imem_addr_o(addr0), .imem_ack_i(ack), .imem_data_i(data0),
    .retire_o(ret0), .retire_pc_o(rpc0), .halted_o(halt0),
    .dbg_raddr_i(ra0), .dbg_rdata_o(dbg0)
  );

  multicycle_cpu #(.XLEN(16), .NREG(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_ack_i(ack), .imem_data_i(data1),
    .retire_o(ret1), .retire_pc_o(rpc1), .halted_o(halt1),
    .dbg_raddr_i(ra1), .dbg_rdata_o(dbg1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) rnd_ack = ($urandom_range(0, wait_max) == 0);

  always @(negedge clk) begin
    if (ret0) q0.push_back(64'(rpc0));
    if (ret1) q1.push_back(64'(rpc1));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] e_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] e_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = HALT;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q0.delete(); q1.delete();
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Instruction-level interpreter: one loop iteration per retired instruction.
  task automatic model(input int k, input int xl, input int aw);
    logic [63:0] msk, pc, a, b, imm, nxt, res;
    logic [63:0] r [32];
    logic [31:0] ins;
    int rs, rt, rd;
    bit wr, done;
    msk = (64'd1 << xl) - 64'd1;
    pc = '0; done = 1'b0; m_n[k] = 0;
    for (int i = 0; i < 32; i++) r[i] = '0;
    for (int s = 0; s < 64 && !done; s++) begin
      ins = mem[pc[7:2]];
      rs  = int'(ins[25:21]) % (1 << aw);
      rt  = int'(ins[20:16]) % (1 << aw);
      rd  = int'(ins[15:11]) % (1 << aw);
      a = r[rs]; b = r[rt];
      imm = {{48{ins[15]}}, ins[15:0]} & msk;
      m_pcs[k][m_n[k]] = pc; m_n[k]++;
      nxt = (pc + 64'd4) & msk; wr = 1'b0; res = '0;
      case (ins[31:26])
        6'h00: begin
          wr = 1'b1;
          case (ins[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h18: res = a * b;
            default: wr = 1'b0;
          endcase
        end
        6'h08: begin wr = 1'b1; rd = rt; res = a + imm; end
        6'h04: if (a == b) nxt = (pc + 64'd4 + (imm << 2)) & msk;
        6'h3F: done = 1'b1;
        default: ;
      endcase
      if (wr && rd != 0) r[rd] = res & msk;
      pc = nxt;
    end
    for (int i = 0; i < 32; i++) m_reg[k][i] = r[i];
  endtask

  task automatic run_prog(input string tag, input int wm, input int budget);
    int cyc;
    model(0, 32, 5);
    model(1, 16, 3);
    wait_max = wm; auto_ack = 1'b1;
    do_reset();
    start_pulse();
    cyc = 0;
    while (!(halt0 && halt1) && cyc < budget) begin
      @(negedge clk); cyc++;
    end
    chk({tag, "_halt_in_budget"}, 64'(cyc < budget), 64'd1);
    @(negedge clk);
    chk({tag, "_nret0"}, 64'(q0.size()), 64'(m_n[0]));
    chk({tag, "_nret1"}, 64'(q1.size()), 64'(m_n[1]));
    for (int i = 0; i < q0.size() && i < m_n[0]; i++) chk($sformatf("%s_pc0[%0d]", tag, i), q0[i], m_pcs[0][i]);
    for (int i = 0; i < q1.size() && i < m_n[1]; i++) chk($sformatf("%s_pc1[%0d]", tag, i), q1[i], m_pcs[1][i]);
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); #1;
      chk($sformatf("%s_r0[%0d]", tag, i), 64'(dbg0), m_reg[0][i]);
    end
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); #1;
      chk($sformatf("%s_r1[%0d]", tag, i), 64'(dbg1), m_reg[1][i]);
    end
  endtask

  function automatic int rnd_reg();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  task automatic gen_random();
    int n, sel, rs;
    clear_mem();
    n = $urandom_range(8, 24);
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 9);
      rs  = rnd_reg();
      case (sel)
        0: mem[i] = e_r(rs, rnd_reg(), rnd_reg(), 6'h20);
        1: mem[i] = e_r(rs, rnd_reg(), rnd_reg(), 6'h22);
        2: mem[i] = e_r(rs, rnd_reg(), rnd_reg(), 6'h24);
        3: mem[i] = e_r(rs, rnd_reg(), rnd_reg(), 6'h25);
        4: mem[i] = e_r(rs, rnd_reg(), rnd_reg(), 6'h18);
        5, 6: mem[i] = e_i(6'h08, rs, rnd_reg(), int'($urandom_range(0, 65535)));
        7: mem[i] = e_i(6'h04, rs, ($urandom_range(0, 1) == 0) ? rs : rnd_reg(), int'($urandom_range(0, 3)));
        8: mem[i] = e_r(rs, rnd_reg(), rnd_reg(), 6'h03);
        default: mem[i] = e_i(6'h0A, rs, rnd_reg(), int'($urandom_range(0, 65535)));
      endcase
    end
  endtask

  initial begin
    int bad, cyc;

    // Reset state
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_req", 64'(req0), 64'd0);
    chk("rst_retire", 64'(ret0), 64'd0);
    chk("rst_retire_pc", 64'(rpc0), 64'd0);
    chk("rst_halted", 64'(halt0), 64'd0);
    chk("rst_addr", 64'(addr0), 64'd0);
    rst = 1'b1;

    // Basic sequence with zero wait states: retire at cycles 4, 8, 12
    clear_mem();
    mem[0] = e_i(6'h08, 0, 1, 5);
    mem[1] = e_i(6'h08, 0, 2, -3);
    mem[2] = e_r(1, 2, 3, 6'h20);
    wait_max = 0; auto_ack = 1'b1;
    do_reset();
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("basic_retire_c%0d", k), 64'(ret0), 64'((k % 4) == 0));
      if ((k % 4) == 0) chk($sformatf("basic_rpc_c%0d", k), 64'(rpc0), 64'((k / 4 - 1) * 4));
    end
    @(negedge clk);
    ra0 = 5'd3; ra1 = 3'd3; #1;
    chk("basic_r3", 64'(dbg0), 64'd2);
    chk("basic_r3_x16", 64'(dbg1), 64'd2);
    ra0 = 5'd2; #1;
    chk("basic_r2", 64'(dbg0), 64'hFFFF_FFFD);

    // ALU operations and write to r0
    clear_mem();
    mem[0] = e_i(6'h08, 0, 1, 6);
    mem[1] = e_i(6'h08, 0, 2, 9);
    mem[2] = e_r(1, 2, 4, 6'h22);
    mem[3] = e_r(1, 2, 5, 6'h24);
    mem[4] = e_r(1, 2, 6, 6'h25);
    mem[5] = e_r(1, 2, 7, 6'h18);
    mem[6] = e_i(6'h08, 0, 0, 7);
    run_prog("alu", 0, 400);
    ra0 = 5'd4; ra1 = 3'd4; #1;
    chk("alu_sub", 64'(dbg0), 64'hFFFF_FFFD);
    chk("alu_sub_x16", 64'(dbg1), 64'hFFFD);
    ra0 = 5'd5; #1; chk("alu_and", 64'(dbg0), 64'd0);
    ra0 = 5'd6; #1; chk("alu_or", 64'(dbg0), 64'd15);
    ra0 = 5'd7; #1; chk("alu_mul", 64'(dbg0), 64'd54);
    ra0 = 5'd0; #1; chk("alu_r0", 64'(dbg0), 64'd0);

    // Branches at 0x10, taken then not taken
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      mem[0] = e_i(6'h08, 0, 1, 1);
      mem[1] = e_i(6'h08, 0, 2, 2);
      mem[2] = 32'h0000_0000;
      mem[3] = 32'h0000_0000;
      mem[4] = e_i(6'h04, 1, (t == 0) ? 1 : 2, 2);
      mem[5] = e_i(6'h08, 0, 3, 1);
      mem[6] = e_i(6'h08, 0, 3, 2);
      run_prog((t == 0) ? "beq_taken" : "beq_not", 1, 800);
      chk((t == 0) ? "beq_taken_next" : "beq_not_next",
          (q0.size() > 5) ? q0[5] : 64'hDEAD, (t == 0) ? 64'h1C : 64'h14);
    end

    // Halt at 0x8
    clear_mem();
    mem[0] = e_i(6'h08, 0, 1, 1);
    mem[1] = e_i(6'h08, 0, 2, 2);
    wait_max = 0; auto_ack = 1'b1;
    do_reset();
    start_pulse();
    cyc = 0;
    while (!ret0 || rpc0 != 32'h8) begin
      if (cyc >= 40) break;
      @(negedge clk); cyc++;
    end
    chk("halt_retire_pc", 64'(rpc0), 64'h8);
    chk("halt_not_yet", 64'(halt0), 64'd0);
    @(negedge clk);
    chk("halt_set", 64'(halt0), 64'd1);
    chk("halt_pc", 64'(addr0), 64'hC);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req0 || req1 || !halt0 || !halt1 || ret0) bad++;
    end
    chk("halt_quiet", 64'(bad), 64'd0);

    // Wait states, start_i mid-instruction, then reset during a pending fetch
    clear_mem();
    mem[0] = e_i(6'h08, 0, 1, 5);
    mem[1] = e_i(6'h08, 0, 2, 7);
    auto_ack = 1'b0; man_ack = 1'b0;
    do_reset();
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k <= 4) begin
        chk($sformatf("ws_req_c%0d", k), 64'(req0), 64'd1);
        chk($sformatf("ws_addr_c%0d", k), 64'(addr0), 64'd0);
      end
      man_ack = (k == 4);
      if (k == 7) begin
        chk("ws_retire", 64'(ret0), 64'd1);
        chk("ws_retire_pc", 64'(rpc0), 64'd0);
      end else begin
        chk($sformatf("ws_noret_c%0d", k), 64'(ret0), 64'd0);
      end
    end
    @(negedge clk);
    chk("ws_next_req", 64'(req0), 64'd1);
    chk("ws_next_addr", 64'(addr0), 64'd4);
    ra0 = 5'd1; #1;
    chk("ws_r1", 64'(dbg0), 64'd5);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_req", 64'(req0), 64'd0);
    chk("mrst_retire", 64'(ret0), 64'd0);
    chk("mrst_halted", 64'(halt0), 64'd0);
    chk("mrst_pc", 64'(addr0), 64'd0);
    chk("mrst_r1", 64'(dbg0), 64'd0);
    rst = 1'b1; man_ack = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ret0 || req0) bad++;
    end
    chk("mrst_idle", 64'(bad), 64'd0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("mrst_restart_req", 64'(req0), 64'd1);
    chk("mrst_restart_addr", 64'(addr0), 64'd0);

    // Random programs with random wait states
    for (int p = 0; p < 8; p++) begin
      gen_random();
      run_prog($sformatf("rnd%0d", p), int'($urandom_range(0, 2)), 4000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
